// File: rtl/watchpoint_unit_pkg.sv
// watchpoint_unit_pkg: shared state encodings, mode constants and compare result type
package watchpoint_unit_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRIGGERED = 2'd2, ACKED = 2'd3} wp_state_t;
  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_EQ  = 2'b01;
  localparam logic [1:0] MODE_IN  = 2'b10;
  localparam logic [1:0] MODE_OUT = 2'b11;
  typedef struct packed {logic lt; logic eq; logic gt;} cmp_t;
endpackage

// File: rtl/wp_range_match.sv
// wp_range_match: two magnitude-compare cascades (address vs lo, address vs hi) reduced to a mode-selected match
module wp_range_match
  import watchpoint_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [1:0]       i_mode,
  output logic             o_match
);
  cmp_t w_vs_lo, w_vs_hi;
  assign w_vs_lo = {i_addr < i_lo, i_addr == i_lo, i_addr > i_lo};
  assign w_vs_hi = {i_addr < i_hi, i_addr == i_hi, i_addr > i_hi};
  // Inverted bounds fall out naturally: inside is empty, outside covers everything
  always_comb
    o_match = i_mode == MODE_EQ  ? w_vs_lo.eq :
              i_mode == MODE_IN  ? (w_vs_lo.gt | w_vs_lo.eq) & (w_vs_hi.lt | w_vs_hi.eq) :
              i_mode == MODE_OUT ? w_vs_lo.lt | w_vs_hi.gt : 1'b0;
endmodule

// File: rtl/watchpoint_unit.sv
// watchpoint_unit: pipelined address watchpoint with hit counter and 4-phase halt handshake
module watchpoint_unit
  import watchpoint_unit_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 ld_lo,
  input  logic                 ld_hi,
  input  logic                 ld_cnt,
  input  logic [1:0]           mode,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [WIDTH-1:0]     addr,
  input  logic                 addr_valid,
  output logic                 hit,
  output logic                 armed,
  output logic                 halt_req,
  input  logic                 halt_ack,
  output logic [CNT_WIDTH-1:0] hits_left
);
  logic [WIDTH-1:0]     r_lo, r_hi, r_addr_q;
  logic                 r_valid_q, r_hit;
  logic [CNT_WIDTH-1:0] r_cnt;
  wp_state_t            r_state, w_next;
  logic                 w_match, w_qual, w_trig;

  wp_range_match #(.WIDTH(WIDTH)) u_match (
    .i_addr (r_addr_q),
    .i_lo   (r_lo),
    .i_hi   (r_hi),
    .i_mode (mode),
    .o_match(w_match)
  );

  assign w_qual = r_valid_q & w_match & (r_state == ARMED);
  assign w_trig = w_qual & (r_cnt <= CNT_WIDTH'(1));

  // Stage 1 address capture and bound registers
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      r_addr_q  <= '0;
      r_valid_q <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
    end else begin
      r_addr_q  <= addr;
      r_valid_q <= addr_valid;
      if (ld_lo) r_lo <= data_in;
      if (ld_hi) r_hi <= data_in;
    end

  // Stage 2 hit pulse and saturating down-counter; a load overrides a decrement
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      r_hit <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_hit <= w_qual;
      r_cnt <= ld_cnt ? data_in[CNT_WIDTH-1:0] : (w_qual && r_cnt > CNT_WIDTH'(1)) ? r_cnt - 1'b1 : r_cnt;
    end

  // State register
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) r_state <= IDLE;
    else r_state <= w_next;

  // Next state: disarm aborts from anywhere, otherwise walk the halt handshake
  always_comb
    w_next = disarm                ? IDLE :
             r_state == IDLE       ? (arm ? ARMED : IDLE) :
             r_state == ARMED      ? (w_trig ? TRIGGERED : ARMED) :
             r_state == TRIGGERED  ? (halt_ack ? ACKED : TRIGGERED) :
                                     (halt_ack ? ACKED : IDLE);

  assign hit       = r_hit;
  assign armed     = r_state == ARMED;
  assign halt_req  = r_state == TRIGGERED;
  assign hits_left = r_cnt;
endmodule
